// File: rtl/param_fetcher_pkg.sv
// rtl/param_fetcher_pkg.sv - shared types and constants for the instruction fetcher
package param_fetcher_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_WAIT = 1'b1
  } fsm_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            pred_jump;
    logic [XLEN-1:0] rollback_pc;
  } fq_entry_t;

  localparam int FQ_ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - first-word-fall-through fetch queue with synchronous flush
module fetch_queue
  import param_fetcher_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FQ_ENTRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             valid
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr;
  logic [PW:0]      count;

  assign full  = (count == (PW+1)'(DEPTH));
  assign valid = (count != '0);
  assign rdata = slots[rptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) slots[wptr] <= wdata;
  end

endmodule

// File: rtl/param_fetcher.sv
// rtl/param_fetcher.sv - direct-mapped I-cache fetcher with prefetch and fetch queue
module param_fetcher
  import param_fetcher_pkg::*;
#(
  parameter int ICACHE_IDX_W = 8,
  parameter int FQ_DEPTH     = 4,
  parameter bit PREFETCH_EN  = 1'b1
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            rdy_in,
  output logic [XLEN-1:0] mem_pc_out,
  output logic            mem_req_out,
  output logic            mem_drop_out,
  input  logic [XLEN-1:0] mem_inst_in,
  input  logic            mem_ok_in,
  output logic [XLEN-1:0] pred_pc_out,
  output logic [XLEN-1:0] pred_inst_out,
  input  logic [XLEN-1:0] pred_imm_in,
  input  logic            pred_jump_in,
  output logic            fq_valid_out,
  input  logic            fq_ready_in,
  output logic [XLEN-1:0] fq_inst_out,
  output logic [XLEN-1:0] fq_pc_out,
  output logic [XLEN-1:0] fq_rollback_pc_out,
  output logic            fq_pred_jump_out,
  input  logic            rollback_in,
  input  logic [XLEN-1:0] rollback_pc_in
);
  localparam int LINES  = 1 << ICACHE_IDX_W;
  localparam int TAG_LO = ICACHE_IDX_W + 2;
  localparam int TAG_W  = XLEN - TAG_LO;

  logic [XLEN-1:0]         pc;
  logic [XLEN-1:0]         seq_pc;
  logic [XLEN-1:0]         req_pc;
  logic [XLEN-1:0]         req_addr;
  logic [LINES-1:0]        line_valid;
  logic [TAG_W-1:0]        line_tag  [LINES];
  logic [XLEN-1:0]         line_data [LINES];
  logic [ICACHE_IDX_W-1:0] idx;
  logic [ICACHE_IDX_W-1:0] seq_idx;
  logic [ICACHE_IDX_W-1:0] fill_idx;
  logic                    hit;
  logic                    seq_hit;
  logic                    push;
  logic                    pop;
  logic                    flush;
  logic                    fill;
  logic                    req_fire;
  logic                    fq_full;
  fsm_state_t              state;
  fsm_state_t              state_next;
  fq_entry_t               wr_entry;
  fq_entry_t               rd_entry;

  assign seq_pc   = pc + 32'd4;
  assign idx      = pc[TAG_LO-1:2];
  assign seq_idx  = seq_pc[TAG_LO-1:2];
  assign fill_idx = req_pc[TAG_LO-1:2];
  assign hit      = line_valid[idx] && (line_tag[idx] == pc[XLEN-1:TAG_LO]);
  assign seq_hit  = line_valid[seq_idx] && (line_tag[seq_idx] == seq_pc[XLEN-1:TAG_LO]);

  assign pred_pc_out   = pc;
  assign pred_inst_out = hit ? line_data[idx] : '0;

  assign flush = rdy_in && rollback_in;
  assign push  = rdy_in && !rollback_in && hit && !fq_full;
  assign pop   = rdy_in && !rollback_in && fq_valid_out && fq_ready_in;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state <= FSM_IDLE;
    else           state <= state_next;
  end

  // Demand miss on pc wins over the sequential prefetch of pc+4
  always_comb begin
    state_next = state;
    req_fire   = 1'b0;
    req_addr   = pc;
    fill       = 1'b0;
    if (rdy_in) begin
      if (rollback_in) begin
        state_next = FSM_IDLE;
      end else begin
        case (state)
          FSM_IDLE: begin
            if (!hit) begin
              req_fire   = 1'b1;
              state_next = FSM_WAIT;
            end else if (PREFETCH_EN && !seq_hit) begin
              req_fire   = 1'b1;
              req_addr   = seq_pc;
              state_next = FSM_WAIT;
            end
          end
          FSM_WAIT: begin
            if (mem_ok_in) begin
              fill       = 1'b1;
              state_next = FSM_IDLE;
            end
          end
          default: state_next = FSM_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      pc           <= '0;
      req_pc       <= '0;
      mem_req_out  <= 1'b0;
      mem_drop_out <= 1'b0;
      mem_pc_out   <= '0;
      line_valid   <= '0;
    end else if (rdy_in) begin
      mem_drop_out <= rollback_in;
      mem_req_out  <= req_fire;
      if (req_fire) begin
        mem_pc_out <= req_addr;
        req_pc     <= req_addr;
      end
      if (rollback_in)  pc <= rollback_pc_in;
      else if (push)    pc <= pc + (pred_jump_in ? pred_imm_in : 32'd4);
      if (fill) line_valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_n_in && fill) begin
      line_tag[fill_idx]  <= req_pc[XLEN-1:TAG_LO];
      line_data[fill_idx] <= mem_inst_in;
    end
  end

  assign wr_entry = '{inst: line_data[idx], pc: pc, pred_jump: pred_jump_in, rollback_pc: seq_pc};

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (FQ_ENTRY_W)
  ) u_fetch_queue (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fq_full),
    .valid (fq_valid_out)
  );

  assign fq_inst_out        = rd_entry.inst;
  assign fq_pc_out          = rd_entry.pc;
  assign fq_pred_jump_out   = rd_entry.pred_jump;
  assign fq_rollback_pc_out = rd_entry.rollback_pc;

endmodule

// File: doc/param_fetcher.md
PARAM_FETCHER -- requirements
Module: param_fetcher

Interface
REQ-001 Parameter ICACHE_IDX_W, default 8, SHALL set the direct-mapped I-cache depth to 2^ICACHE_IDX_W one-word lines.
REQ-002 Parameter FQ_DEPTH, default 4, SHALL set the fetch-queue depth; legal values are powers of two, at least 2.
REQ-003 Parameter PREFETCH_EN, default 1, SHALL enable sequential next-line prefetch.
REQ-004 Port clk_in, in, 1: the single clock; all logic SHALL update on its rising edge.
REQ-005 Port rst_n_in, in, 1: reset, synchronous, active-low.
REQ-006 Port rdy_in, in, 1: global enable; when low, all state SHALL hold.
REQ-007 Ports mem_pc_out (out, 32), mem_req_out (out, 1), mem_drop_out (out, 1), mem_inst_in (in, 32), mem_ok_in (in, 1): the memory-controller word-fetch channel.
REQ-008 Ports pred_pc_out (out, 32), pred_inst_out (out, 32), pred_imm_in (in, 32), pred_jump_in (in, 1): the combinational branch-predictor query.
REQ-009 Ports fq_valid_out (out, 1) and fq_ready_in (in, 1): the dispatcher handshake.
REQ-010 Ports fq_inst_out, fq_pc_out and fq_rollback_pc_out (out, 32 each) and fq_pred_jump_out (out, 1): the fetch-queue head entry.
REQ-011 Ports rollback_in (in, 1) and rollback_pc_in (in, 32): the RoB redirect.

Function
REQ-012 The cache lookup SHALL be combinational: index = pc[ICACHE_IDX_W+1:2], tag = pc[31:ICACHE_IDX_W+2], hit = valid[index] && tag match.
REQ-013 pred_pc_out SHALL equal pc, and pred_inst_out SHALL equal the cached word on a hit and 0 on a miss.
REQ-014 Push condition: hit && count<FQ_DEPTH && !rollback_in. On push, the queue SHALL write {inst, pc, pred_jump_in, pc+4} and set pc <= pc + (pred_jump_in ? pred_imm_in : 4), modulo 2^32.
REQ-015 When the queue is full, a push SHALL NOT occur in that cycle, even if a pop occurs in the same cycle.
REQ-016 Pop condition: fq_valid_out && fq_ready_in. The queue SHALL be first-word-fall-through: head fields are valid whenever fq_valid_out=1, and fq_valid_out = (count!=0).
REQ-017 count SHALL range 0..FQ_DEPTH; a simultaneous push and pop SHALL leave count unchanged; read and write pointers SHALL wrap modulo FQ_DEPTH.
REQ-018 The miss FSM SHALL have states IDLE and WAIT.
REQ-019 In IDLE with pc missing, the FSM SHALL issue mem_req_out=1 for exactly one cycle with mem_pc_out=pc, latch req_pc=pc, and move to WAIT.
REQ-020 In IDLE with pc hitting, PREFETCH_EN=1, and pc+4 missing, the FSM SHALL issue the same request for pc+4.
REQ-021 In IDLE with no request condition, the FSM SHALL remain in IDLE.
REQ-022 In WAIT, on mem_ok_in=1, the FSM SHALL write line req_pc (valid, tag, data = mem_inst_in) and return to IDLE; the fill SHALL become visible to lookup on the next cycle.
REQ-023 Minimum miss-to-enqueue latency SHALL be mem latency + 2 cycles.
REQ-024 Rollback SHALL take priority over every other event: count <= 0, pc <= rollback_pc_in, FSM <= IDLE, mem_req_out <= 0, mem_drop_out <= 1 for exactly one cycle. Any mem_ok_in in that cycle SHALL be discarded, and cache contents SHALL be retained.
REQ-025 mem_drop_out SHALL be 0 in every cycle except the one following a rollback.
REQ-026 While rdy_in=0, the block SHALL neither push nor pop nor change FSM state, and outputs SHALL hold their values.

Reset
REQ-027 While rst_n_in=0 at a clock edge: pc=0, FSM=IDLE, count=0, all pointers 0, all valid bits 0, and mem_req_out, mem_drop_out and mem_pc_out = 0.
REQ-028 Reset SHALL override rdy_in and rollback_in and SHALL abort an outstanding miss; a mem_ok_in arriving after reset SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the fetch-queue entry struct width, and the XLEN=32 constant.
REQ-030 The fetch queue SHALL be a sub-module named fetch_queue, parametrised by FQ_DEPTH and entry width.

Verification
REQ-031 Cold start: reset, then memory returns 0x00000013 at addr 0 after 3 cycles -> mem_req_out pulses with mem_pc_out=0x0; entry {0x13, pc 0x0, rollback 0x4} appears with fq_valid_out=1 two cycles after mem_ok_in.
REQ-032 Back-pressure: hold fq_ready_in=0 with the cache pre-warmed for 0x0-0x1C -> exactly FQ_DEPTH pushes, count=4, pc stops at 0x10; releasing ready drains entries in order 0x0, 0x4, 0x8, 0xC.
REQ-033 Predicted jump: at pc=0x8, pred_jump_in=1 and pred_imm_in=0x100 -> next pc=0x108; the queued entry has fq_pred_jump_out=1 and fq_rollback_pc_out=0xC.
REQ-034 Rollback during WAIT: rollback_pc_in=0x40 arrives in the same cycle as mem_ok_in -> fill discarded, count=0, mem_drop_out=1 for one cycle, next mem_pc_out=0x40.
REQ-035 Index alias with ICACHE_IDX_W=8: fill 0x0, then fetch 0x400 -> miss, refill; then 0x0 misses again.
